// File: rtl/branch_resolve_queue.sv
// Circular in-order queue of in-flight conditional branches. Entries are allocated at dispatch,
// resolved out of order, and retired in program order (up to two per cycle) with predictor training.
module branch_resolve_queue #(
    parameter int BRQ_SIZE = 8,
    parameter int IDX_W    = $clog2(BRQ_SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc1_valid,
    input  logic [63:0]      alloc1_pc,
    input  logic             alloc1_predict,
    input  logic [63:0]      alloc1_pred_target,
    input  logic             alloc2_valid,
    input  logic [63:0]      alloc2_pc,
    input  logic             alloc2_predict,
    input  logic [63:0]      alloc2_pred_target,
    output logic             alloc1_ready,
    output logic             alloc2_ready,
    output logic [IDX_W-1:0] alloc1_idx,
    output logic [IDX_W-1:0] alloc2_idx,
    input  logic             resolve1_valid,
    input  logic [IDX_W-1:0] resolve1_idx,
    input  logic             resolve1_taken,
    input  logic [63:0]      resolve1_target,
    input  logic             resolve2_valid,
    input  logic [IDX_W-1:0] resolve2_idx,
    input  logic             resolve2_taken,
    input  logic [63:0]      resolve2_target,
    output logic             upd1_valid,
    output logic [63:0]      upd1_pc,
    output logic             upd1_taken,
    output logic             upd2_valid,
    output logic [63:0]      upd2_pc,
    output logic             upd2_taken,
    output logic             mispredict_valid,
    output logic [63:0]      redirect_pc,
    output logic [IDX_W:0]   free_count
);
    localparam logic [IDX_W:0] SIZE_C = (IDX_W+1)'(BRQ_SIZE);

    function automatic logic is_mispredict(input logic predict, input logic taken,
                                           input logic [63:0] pred_target,
                                           input logic [63:0] target);
        return (predict != taken) || (taken && (target != pred_target));
    endfunction

    logic [BRQ_SIZE-1:0] valid_r;
    logic [BRQ_SIZE-1:0] done_r;
    logic [BRQ_SIZE-1:0] predict_r;
    logic [BRQ_SIZE-1:0] taken_r;
    logic [63:0]         pc_r          [BRQ_SIZE];
    logic [63:0]         pred_target_r [BRQ_SIZE];
    logic [63:0]         target_r      [BRQ_SIZE];

    logic [IDX_W-1:0] head_r;
    logic [IDX_W-1:0] tail_r;
    logic [IDX_W:0]   count_r;
    logic [IDX_W:0]   free_count_r;
    logic             upd1_valid_r;
    logic [63:0]      upd1_pc_r;
    logic             upd1_taken_r;
    logic             upd2_valid_r;
    logic [63:0]      upd2_pc_r;
    logic             upd2_taken_r;
    logic             mispredict_valid_r;
    logic [63:0]      redirect_pc_r;

    logic [IDX_W:0]   free_s;
    logic [IDX_W:0]   count_next_s;
    logic [IDX_W-1:0] head1_s;
    logic [IDX_W-1:0] head_next_s;
    logic [IDX_W-1:0] tail_next_s;
    logic [IDX_W-1:0] ret_idx_s;
    logic [1:0]       pops_s;
    logic [1:0]       allocs_s;
    logic             pop0_s;
    logic             pop1_s;
    logic             mis0_s;
    logic             mis1_s;
    logic             flush_s;
    logic             alloc1_wr_s;
    logic             alloc2_wr_s;
    logic             res1_wr_s;
    logic             res2_wr_s;

    // Availability reflects only registered occupancy; same-cycle retirements are not credited.
    assign free_s       = SIZE_C - count_r;
    assign alloc1_ready = (free_s >= (IDX_W+1)'(1));
    assign alloc2_ready = (free_s >= (IDX_W+1)'(2));
    assign alloc1_idx   = tail_r;
    assign alloc2_idx   = alloc1_valid ? (tail_r + IDX_W'(1)) : tail_r;

    assign upd1_valid       = upd1_valid_r;
    assign upd1_pc          = upd1_pc_r;
    assign upd1_taken       = upd1_taken_r;
    assign upd2_valid       = upd2_valid_r;
    assign upd2_pc          = upd2_pc_r;
    assign upd2_taken       = upd2_taken_r;
    assign mispredict_valid = mispredict_valid_r;
    assign redirect_pc      = redirect_pc_r;
    assign free_count       = free_count_r;

    // Retire, flush, allocation and resolution decisions for this edge.
    always_comb begin
        head1_s  = head_r + IDX_W'(1);
        pop0_s   = valid_r[head_r] & done_r[head_r];
        mis0_s   = pop0_s & is_mispredict(predict_r[head_r], taken_r[head_r],
                                          pred_target_r[head_r], target_r[head_r]);
        pop1_s   = pop0_s & ~mis0_s & valid_r[head1_s] & done_r[head1_s];
        // A mispredicted second retiree still needs its redirect.
        mis1_s   = pop1_s & is_mispredict(predict_r[head1_s], taken_r[head1_s],
                                          pred_target_r[head1_s], target_r[head1_s]);
        flush_s  = mis0_s | mis1_s;
        ret_idx_s = mis1_s ? head1_s : head_r;
        pops_s   = {1'b0, pop0_s} + {1'b0, pop1_s};

        alloc1_wr_s = alloc1_valid & alloc1_ready & ~flush_s;
        alloc2_wr_s = alloc2_valid & ~flush_s & (alloc1_valid ? alloc2_ready : alloc1_ready);
        allocs_s    = {1'b0, alloc1_wr_s} + {1'b0, alloc2_wr_s};

        res1_wr_s = resolve1_valid & valid_r[resolve1_idx] & ~done_r[resolve1_idx] & ~flush_s;
        res2_wr_s = resolve2_valid & valid_r[resolve2_idx] & ~done_r[resolve2_idx] & ~flush_s
                    & ~(resolve1_valid & (resolve1_idx == resolve2_idx));

        head_next_s  = head_r + IDX_W'(pops_s);
        tail_next_s  = flush_s ? head_next_s : (tail_r + IDX_W'(allocs_s));
        count_next_s = flush_s ? {(IDX_W+1){1'b0}}
                               : (count_r - (IDX_W+1)'(pops_s) + (IDX_W+1)'(allocs_s));
    end

    // Pointers, entry valid/done bits and the registered training/redirect pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r            <= {BRQ_SIZE{1'b0}};
            done_r             <= {BRQ_SIZE{1'b0}};
            head_r             <= {IDX_W{1'b0}};
            tail_r             <= {IDX_W{1'b0}};
            count_r            <= {(IDX_W+1){1'b0}};
            free_count_r       <= SIZE_C;
            upd1_valid_r       <= 1'b0;
            upd1_pc_r          <= 64'd0;
            upd1_taken_r       <= 1'b0;
            upd2_valid_r       <= 1'b0;
            upd2_pc_r          <= 64'd0;
            upd2_taken_r       <= 1'b0;
            mispredict_valid_r <= 1'b0;
            redirect_pc_r      <= 64'd0;
        end else begin
            head_r             <= head_next_s;
            tail_r             <= tail_next_s;
            count_r            <= count_next_s;
            free_count_r       <= SIZE_C - count_next_s;
            upd1_valid_r       <= pop0_s;
            upd1_pc_r          <= pop0_s ? pc_r[head_r] : 64'd0;
            upd1_taken_r       <= pop0_s & taken_r[head_r];
            upd2_valid_r       <= pop1_s;
            upd2_pc_r          <= pop1_s ? pc_r[head1_s] : 64'd0;
            upd2_taken_r       <= pop1_s & taken_r[head1_s];
            mispredict_valid_r <= flush_s;
            redirect_pc_r      <= !flush_s ? 64'd0
                                : (taken_r[ret_idx_s] ? target_r[ret_idx_s]
                                                      : (pc_r[ret_idx_s] + 64'd4));
            if (flush_s) begin
                valid_r <= {BRQ_SIZE{1'b0}};
                done_r  <= {BRQ_SIZE{1'b0}};
            end else begin
                if (pop0_s) begin
                    valid_r[head_r] <= 1'b0;
                    done_r[head_r]  <= 1'b0;
                end
                if (pop1_s) begin
                    valid_r[head1_s] <= 1'b0;
                    done_r[head1_s]  <= 1'b0;
                end
                if (res2_wr_s) begin
                    done_r[resolve2_idx] <= 1'b1;
                end
                if (res1_wr_s) begin
                    done_r[resolve1_idx] <= 1'b1;
                end
                if (alloc1_wr_s) begin
                    valid_r[tail_r] <= 1'b1;
                    done_r[tail_r]  <= 1'b0;
                end
                if (alloc2_wr_s) begin
                    valid_r[alloc2_idx] <= 1'b1;
                    done_r[alloc2_idx]  <= 1'b0;
                end
            end
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set, so it needs no reset.
    always_ff @(posedge clock) begin
        if (alloc1_wr_s) begin
            pc_r[tail_r]          <= alloc1_pc;
            predict_r[tail_r]     <= alloc1_predict;
            pred_target_r[tail_r] <= alloc1_pred_target;
        end
        if (alloc2_wr_s) begin
            pc_r[alloc2_idx]          <= alloc2_pc;
            predict_r[alloc2_idx]     <= alloc2_predict;
            pred_target_r[alloc2_idx] <= alloc2_pred_target;
        end
        if (res2_wr_s) begin
            taken_r[resolve2_idx]  <= resolve2_taken;
            target_r[resolve2_idx] <= resolve2_target;
        end
        if (res1_wr_s) begin
            taken_r[resolve1_idx]  <= resolve1_taken;
            target_r[resolve1_idx] <= resolve1_target;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: allocation, out-of-order resolve, in-order retire,
// mispredict flush/redirect, full-queue wrap and mid-operation reset.
module tb_branch_resolve_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        alloc1_valid, alloc1_predict, alloc2_valid, alloc2_predict;
    logic [63:0] alloc1_pc, alloc1_pred_target, alloc2_pc, alloc2_pred_target;
    logic        alloc1_ready, alloc2_ready;
    logic [2:0]  alloc1_idx, alloc2_idx;
    logic        resolve1_valid, resolve1_taken, resolve2_valid, resolve2_taken;
    logic [2:0]  resolve1_idx, resolve2_idx;
    logic [63:0] resolve1_target, resolve2_target;
    logic        upd1_valid, upd1_taken, upd2_valid, upd2_taken, mispredict_valid;
    logic [63:0] upd1_pc, upd2_pc, redirect_pc;
    logic [3:0]  free_count;

    int errors = 0;
    int checks = 0;

    branch_resolve_queue #(.BRQ_SIZE(8)) dut (
        .clock(clock), .reset(reset),
        .alloc1_valid(alloc1_valid), .alloc1_pc(alloc1_pc), .alloc1_predict(alloc1_predict),
        .alloc1_pred_target(alloc1_pred_target),
        .alloc2_valid(alloc2_valid), .alloc2_pc(alloc2_pc), .alloc2_predict(alloc2_predict),
        .alloc2_pred_target(alloc2_pred_target),
        .alloc1_ready(alloc1_ready), .alloc2_ready(alloc2_ready),
        .alloc1_idx(alloc1_idx), .alloc2_idx(alloc2_idx),
        .resolve1_valid(resolve1_valid), .resolve1_idx(resolve1_idx),
        .resolve1_taken(resolve1_taken), .resolve1_target(resolve1_target),
        .resolve2_valid(resolve2_valid), .resolve2_idx(resolve2_idx),
        .resolve2_taken(resolve2_taken), .resolve2_target(resolve2_target),
        .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
        .upd2_valid(upd2_valid), .upd2_pc(upd2_pc), .upd2_taken(upd2_taken),
        .mispredict_valid(mispredict_valid), .redirect_pc(redirect_pc),
        .free_count(free_count)
    );

    always #5 clock = ~clock;

    task automatic clear_inputs();
        alloc1_valid = 1'b0; alloc1_pc = 64'd0; alloc1_predict = 1'b0; alloc1_pred_target = 64'd0;
        alloc2_valid = 1'b0; alloc2_pc = 64'd0; alloc2_predict = 1'b0; alloc2_pred_target = 64'd0;
        resolve1_valid = 1'b0; resolve1_idx = 3'd0; resolve1_taken = 1'b0; resolve1_target = 64'd0;
        resolve2_valid = 1'b0; resolve2_idx = 3'd0; resolve2_taken = 1'b0; resolve2_target = 64'd0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_free_count got=%0d exp=%0d", free_count, 4'd8); end
        checks++; if (alloc1_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc1_ready got=%0b exp=1", alloc1_ready); end
        checks++; if (alloc2_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc2_ready got=%0b exp=1", alloc2_ready); end
        checks++; if ({upd1_valid, upd2_valid, mispredict_valid} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%03b exp=000", {upd1_valid, upd2_valid, mispredict_valid}); end
        checks++; if (redirect_pc !== 64'd0) begin errors++; $display("FAIL reset_redirect_pc got=%0h exp=0", redirect_pc); end
        checks++; if (alloc1_idx !== 3'd0) begin errors++; $display("FAIL reset_alloc1_idx got=%0d exp=0", alloc1_idx); end
    endtask

    task automatic test_dual_retire();
        do_reset();
        alloc1_valid = 1'b1; alloc1_pc = 64'h100; alloc1_predict = 1'b1; alloc1_pred_target = 64'h200;
        alloc2_valid = 1'b1; alloc2_pc = 64'h104; alloc2_predict = 1'b0;
        #1;
        checks++; if ({alloc1_idx, alloc2_idx} !== {3'd0, 3'd1}) begin errors++; $display("FAIL dual_alloc_idx got=%0d/%0d exp=0/1", alloc1_idx, alloc2_idx); end
        step(); clear_inputs();
        checks++; if (free_count !== 4'd6) begin errors++; $display("FAIL dual_free_after_alloc got=%0d exp=6", free_count); end
        resolve1_valid = 1'b1; resolve1_idx = 3'd1; resolve1_taken = 1'b0; resolve1_target = 64'h108;
        step(); clear_inputs();
        resolve1_valid = 1'b1; resolve1_idx = 3'd0; resolve1_taken = 1'b1; resolve1_target = 64'h200;
        step(); clear_inputs();
        checks++; if (upd1_valid !== 1'b0) begin errors++; $display("FAIL dual_early_upd1 got=%0b exp=0", upd1_valid); end
        step();
        checks++; if ({upd1_valid, upd1_pc, upd1_taken} !== {1'b1, 64'h100, 1'b1}) begin errors++; $display("FAIL dual_upd1 got=%0b/%0h/%0b exp=1/100/1", upd1_valid, upd1_pc, upd1_taken); end
        checks++; if ({upd2_valid, upd2_pc, upd2_taken} !== {1'b1, 64'h104, 1'b0}) begin errors++; $display("FAIL dual_upd2 got=%0b/%0h/%0b exp=1/104/0", upd2_valid, upd2_pc, upd2_taken); end
        checks++; if (mispredict_valid !== 1'b0) begin errors++; $display("FAIL dual_mispredict got=%0b exp=0", mispredict_valid); end
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL dual_free_after_retire got=%0d exp=8", free_count); end
        step();
        checks++; if ({upd1_valid, upd2_valid} !== 2'b00) begin errors++; $display("FAIL dual_pulse_width got=%02b exp=00", {upd1_valid, upd2_valid}); end
    endtask

    task automatic test_taken_mispredict();
        do_reset();
        alloc1_valid = 1'b1; alloc1_pc = 64'h100; alloc1_predict = 1'b0;
        alloc2_valid = 1'b1; alloc2_pc = 64'h104; alloc2_predict = 1'b0;
        step(); clear_inputs();
        alloc1_valid = 1'b1; alloc1_pc = 64'h108; alloc1_predict = 1'b1; alloc1_pred_target = 64'h500;
        step(); clear_inputs();
        checks++; if (free_count !== 4'd5) begin errors++; $display("FAIL tmis_free_after_alloc got=%0d exp=5", free_count); end
        resolve1_valid = 1'b1; resolve1_idx = 3'd0; resolve1_taken = 1'b1; resolve1_target = 64'h300;
        step(); clear_inputs();
        resolve1_valid = 1'b1; resolve1_idx = 3'd1; resolve1_taken = 1'b0;
        step();
        checks++; if ({upd1_valid, upd1_pc, upd1_taken} !== {1'b1, 64'h100, 1'b1}) begin errors++; $display("FAIL tmis_upd1 got=%0b/%0h/%0b exp=1/100/1", upd1_valid, upd1_pc, upd1_taken); end
        checks++; if (upd2_valid !== 1'b0) begin errors++; $display("FAIL tmis_upd2 got=%0b exp=0", upd2_valid); end
        checks++; if ({mispredict_valid, redirect_pc} !== {1'b1, 64'h300}) begin errors++; $display("FAIL tmis_redirect got=%0b/%0h exp=1/300", mispredict_valid, redirect_pc); end
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL tmis_free got=%0d exp=8", free_count); end
        checks++; if (alloc1_idx !== 3'd1) begin errors++; $display("FAIL tmis_tail got=%0d exp=1", alloc1_idx); end
        step(); clear_inputs();
        checks++; if ({upd1_valid, mispredict_valid} !== 2'b00) begin errors++; $display("FAIL tmis_after1 got=%02b exp=00", {upd1_valid, mispredict_valid}); end
        step();
        checks++; if ({upd1_valid, upd2_valid} !== 2'b00) begin errors++; $display("FAIL tmis_flushed_idx1 got=%02b exp=00", {upd1_valid, upd2_valid}); end
    endtask

    task automatic test_not_taken_mispredict();
        do_reset();
        alloc1_valid = 1'b1; alloc1_pc = 64'h240; alloc1_predict = 1'b1; alloc1_pred_target = 64'h400;
        step(); clear_inputs();
        resolve1_valid = 1'b1; resolve1_idx = 3'd0; resolve1_taken = 1'b0; resolve1_target = 64'h999;
        step(); clear_inputs();
        checks++; if (mispredict_valid !== 1'b0) begin errors++; $display("FAIL ntmis_early got=%0b exp=0", mispredict_valid); end
        step();
        checks++; if ({mispredict_valid, redirect_pc} !== {1'b1, 64'h244}) begin errors++; $display("FAIL ntmis_redirect got=%0b/%0h exp=1/244", mispredict_valid, redirect_pc); end
        checks++; if ({upd1_valid, upd1_pc, upd1_taken} !== {1'b1, 64'h240, 1'b0}) begin errors++; $display("FAIL ntmis_upd1 got=%0b/%0h/%0b exp=1/240/0", upd1_valid, upd1_pc, upd1_taken); end
    endtask

    task automatic test_port_priority();
        do_reset();
        alloc1_valid = 1'b1; alloc1_pc = 64'h300; alloc1_predict = 1'b1; alloc1_pred_target = 64'h380;
        step(); clear_inputs();
        resolve1_valid = 1'b1; resolve1_idx = 3'd0; resolve1_taken = 1'b1; resolve1_target = 64'h380;
        resolve2_valid = 1'b1; resolve2_idx = 3'd0; resolve2_taken = 1'b0; resolve2_target = 64'h0;
        step(); clear_inputs();
        step();
        checks++; if ({upd1_valid, upd1_taken, mispredict_valid} !== 3'b110) begin errors++; $display("FAIL prio_port1_wins got=%03b exp=110", {upd1_valid, upd1_taken, mispredict_valid}); end
    endtask

    task automatic test_full_queue();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc1_valid = 1'b1; alloc1_pc = 64'h1000 + 64'(8 * i);
            alloc2_valid = 1'b1; alloc2_pc = 64'h1004 + 64'(8 * i);
            step();
        end
        clear_inputs();
        checks++; if ({alloc2_ready, free_count} !== {1'b1, 4'd2}) begin errors++; $display("FAIL full_six got=%0b/%0d exp=1/2", alloc2_ready, free_count); end
        alloc1_valid = 1'b1; alloc1_pc = 64'h1018;
        step(); clear_inputs();
        checks++; if ({alloc1_ready, alloc2_ready, free_count} !== {2'b10, 4'd1}) begin errors++; $display("FAIL full_seven got=%0b%0b/%0d exp=10/1", alloc1_ready, alloc2_ready, free_count); end
        alloc1_valid = 1'b1; alloc1_pc = 64'h101c;
        step(); clear_inputs();
        checks++; if ({alloc1_ready, free_count, alloc1_idx} !== {1'b0, 4'd0, 3'd0}) begin errors++; $display("FAIL full_eight got=%0b/%0d/%0d exp=0/0/0", alloc1_ready, free_count, alloc1_idx); end
        alloc1_valid = 1'b1; alloc1_pc = 64'h1020;
        step(); clear_inputs();
        checks++; if ({free_count, alloc1_idx} !== {4'd0, 3'd0}) begin errors++; $display("FAIL full_ninth_dropped got=%0d/%0d exp=0/0", free_count, alloc1_idx); end
        resolve1_valid = 1'b1; resolve1_idx = 3'd0; resolve1_taken = 1'b0;
        step(); clear_inputs();
        step();
        checks++; if ({upd1_valid, upd1_pc, upd2_valid} !== {1'b1, 64'h1000, 1'b0}) begin errors++; $display("FAIL full_retire got=%0b/%0h/%0b exp=1/1000/0", upd1_valid, upd1_pc, upd2_valid); end
        checks++; if ({alloc1_ready, free_count, alloc1_idx} !== {1'b1, 4'd1, 3'd0}) begin errors++; $display("FAIL full_reopen got=%0b/%0d/%0d exp=1/1/0", alloc1_ready, free_count, alloc1_idx); end
        alloc1_valid = 1'b1; alloc1_pc = 64'h2000;
        step(); clear_inputs();
        checks++; if ({free_count, alloc1_idx} !== {4'd0, 3'd1}) begin errors++; $display("FAIL full_wrap_alloc got=%0d/%0d exp=0/1", free_count, alloc1_idx); end
        for (int i = 0; i < 4; i++) begin
            resolve1_valid = 1'b1; resolve1_idx = 3'(2 * i + 1); resolve1_taken = 1'b0;
            resolve2_valid = 1'b1; resolve2_idx = 3'(2 * i + 2); resolve2_taken = 1'b0;
            step();
        end
        clear_inputs();
        checks++; if ({upd1_pc, upd2_pc} !== {64'h1014, 64'h1018}) begin errors++; $display("FAIL full_pair56 got=%0h/%0h exp=1014/1018", upd1_pc, upd2_pc); end
        step();
        checks++; if ({upd1_valid, upd1_pc, upd2_valid, upd2_pc} !== {1'b1, 64'h101c, 1'b1, 64'h2000}) begin errors++; $display("FAIL full_pair70 got=%0b/%0h/%0b/%0h exp=1/101c/1/2000", upd1_valid, upd1_pc, upd2_valid, upd2_pc); end
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL full_drained got=%0d exp=8", free_count); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        alloc1_valid = 1'b1; alloc1_pc = 64'h500; alloc2_valid = 1'b1; alloc2_pc = 64'h504;
        step();
        alloc1_pc = 64'h508; alloc2_pc = 64'h50c;
        step(); clear_inputs();
        alloc1_valid = 1'b1; alloc1_pc = 64'h510;
        step(); clear_inputs();
        resolve1_valid = 1'b1; resolve1_idx = 3'd1; resolve1_taken = 1'b0;
        resolve2_valid = 1'b1; resolve2_idx = 3'd2; resolve2_taken = 1'b0;
        step(); clear_inputs();
        checks++; if (free_count !== 4'd3) begin errors++; $display("FAIL rmid_before got=%0d exp=3", free_count); end
        reset = 1'b1;
        resolve1_valid = 1'b1; resolve1_idx = 3'd0; resolve1_taken = 1'b0;
        step();
        reset = 1'b0; clear_inputs();
        checks++; if ({free_count, alloc1_idx, upd1_valid, mispredict_valid} !== {4'd8, 3'd0, 2'b00}) begin errors++; $display("FAIL rmid_after got=%0d/%0d/%0b/%0b exp=8/0/0/0", free_count, alloc1_idx, upd1_valid, mispredict_valid); end
        resolve1_valid = 1'b1; resolve1_idx = 3'd0; resolve1_taken = 1'b1; resolve1_target = 64'h700;
        step(); clear_inputs();
        step();
        checks++; if ({upd1_valid, upd2_valid, mispredict_valid} !== 3'b000) begin errors++; $display("FAIL rmid_no_pulse got=%03b exp=000", {upd1_valid, upd2_valid, mispredict_valid}); end
        alloc1_valid = 1'b1; alloc1_pc = 64'h600;
        step(); clear_inputs();
        resolve1_valid = 1'b1; resolve1_idx = 3'd0; resolve1_taken = 1'b0;
        step(); clear_inputs();
        step();
        checks++; if ({upd1_valid, upd1_pc, upd2_valid} !== {1'b1, 64'h600, 1'b0}) begin errors++; $display("FAIL rmid_head_zero got=%0b/%0h/%0b exp=1/600/0", upd1_valid, upd1_pc, upd2_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_dual_retire();
        test_taken_mispredict();
        test_not_taken_mispredict();
        test_port_priority();
        test_full_queue();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Circular in-order queue of in-flight conditional branches, allocated at dispatch and resolved out of order by the execution units.
- Retires resolved branches in program order, up to 2 per cycle.
- For each retired branch, drives the local-history predictor's training ports (branch_valid1/2, branch_pc1/2, branch_result1/2).
- Raises a single mispredict redirect and flushes all younger entries.

Parameters:
BRQ_SIZE, 8, number of entries; must be a power of two, at least 4.
IDX_W, $clog2(BRQ_SIZE), entry index width.

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
alloc1_valid  in  1  allocate older dispatched branch
alloc1_pc  in  64  branch PC
alloc1_predict  in  1  predicted direction (1 = taken)
alloc1_pred_target  in  64  predicted target; ignored when predict=0
alloc2_valid  in  1  allocate younger dispatched branch
alloc2_pc / alloc2_predict / alloc2_pred_target  in  64/1/64  as alloc1
alloc1_ready  out  1  at least 1 free entry
alloc2_ready  out  1  at least 2 free entries
alloc1_idx  out  IDX_W  entry index assigned to alloc1
alloc2_idx  out  IDX_W  entry index assigned to alloc2
resolve1_valid  in  1  execution result, port 1
resolve1_idx  in  IDX_W  entry being resolved
resolve1_taken  in  1  actual direction
resolve1_target  in  64  actual target
resolve2_valid / resolve2_idx / resolve2_taken / resolve2_target  in  1/IDX_W/1/64  port 2
upd1_valid, upd1_pc, upd1_taken  out  1/64/1  predictor training, older retiree
upd2_valid, upd2_pc, upd2_taken  out  1/64/1  predictor training, younger retiree
mispredict_valid  out  1  redirect pulse
redirect_pc  out  64  correct fetch PC
free_count  out  IDX_W+1  free entries

Behaviour:
- State: head, tail (IDX_W bits, wrap modulo BRQ_SIZE) and count (IDX_W+1 bits).
- Per-entry fields: valid, done, pc, predict, pred_target, taken, target.
- Reset: all entry valid/done bits 0, head=tail=count=0.
  - All registered outputs 0.
  - free_count=BRQ_SIZE; alloc1_ready=alloc2_ready=1.
- Reset mid-operation discards every entry; no update or redirect is emitted for discarded entries.
- alloc ready/idx are combinational from current state:
  - alloc1_ready = (BRQ_SIZE-count >= 1); alloc2_ready = (BRQ_SIZE-count >= 2).
  - Same-cycle retirements are not credited.
  - alloc1_idx = tail.
  - alloc2_idx = tail+1 if alloc1_valid, else tail.
- Allocation at the edge:
  - alloc1 is written if alloc1_valid & alloc1_ready.
  - alloc2 is written if alloc2_valid and free slots cover both requests.
  - tail advances by the number written.
  - An allocation without ready is dropped silently.
- Resolution at the edge: sets done and stores taken/target, only if the indexed entry is valid and not already done. Otherwise it is ignored.
  - Both ports naming the same idx: port 1 wins.
- Entry mispredicted: predict != taken, or (taken & target != pred_target).
- Retire evaluates registered state each edge, so a resolve presented in cycle c produces upd outputs in cycle c+2.
  - Head valid & done: pop head; next cycle upd1_valid=1, upd1_pc=pc, upd1_taken=taken.
  - Head not mispredicted and head+1 valid & done: also pop it to upd2.
  - Otherwise upd2_valid=0. upd2 never fires without upd1.
- Head mispredicted, at the same edge:
  - Pop head and emit upd1.
  - Flush all younger entries: valid=0, done=0.
  - Drop this cycle's allocations and resolutions.
  - Set tail=head+1 and count=0.
  - Next cycle: mispredict_valid=1, redirect_pc = taken ? target : pc+4.
- All upd*/mispredict outputs are registered 1-cycle pulses; they are 0 in any cycle with no retirement.
- count_next = count − pops + allocs, or 0 on mispredict; free_count is registered BRQ_SIZE−count.
- Simultaneous alloc, resolve and retire on different entries are all honoured in the same edge.

Test Plan:
1. Reset then idle -> free_count=8, alloc1_ready=alloc2_ready=1, all upd/mispredict outputs 0.
2. Dual alloc, out-of-order resolve, dual retire:
   - Stimulus: alloc pc 0x100 (predict 1, target 0x200) and pc 0x104 (predict 0); resolve idx1 not-taken, next cycle idx0 taken to 0x200.
   - Response: idx 0/1; two cycles after the idx0 resolve, upd1={1,0x100,1} and upd2={1,0x104,0}; mispredict_valid=0; free_count back to 8.
3. Taken mispredict with flush:
   - Stimulus: alloc 3 branches, pc 0x100 predict 0 first; resolve idx0 taken to 0x300; a later resolve of idx1 is ignored.
   - Response: upd1={1,0x100,1}, mispredict_valid=1, redirect_pc=0x300, free_count=8; no update for idx1.
4. Not-taken mispredict: pc 0x240, predict 1, target 0x400, resolved not-taken -> redirect_pc=0x244, upd1_taken=0.
5. Full queue:
   - Stimulus: 8 allocations.
   - Response: alloc1_ready=0 and a 9th alloc is dropped (tail unchanged); after one retirement, alloc1_ready=1 and the next alloc gets idx 0 (wrap from 7).
6. Reset asserted with 5 valid entries, 2 of them resolved -> no upd pulses afterwards, free_count=8, head=tail=0.
